// File: rtl/icache_pkg.sv
// Shared widths, status-bit layout and FSM encoding for the icache array updater.
package icache_pkg;

    localparam int SET_BITS_WIDTH = 4;
    localparam int TAG_WIDTH      = 8;
    localparam int NUM_WAYS       = 4;
    localparam int WAY_BITS       = 2;
    localparam int STATUS_WIDTH   = 2;
    localparam int TA_WORD_WIDTH  = 32;
    localparam int SA_WORD_WIDTH  = 8;

    localparam int VALID_BIT  = 1;
    localparam int RECENT_BIT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/icache_plru.sv
// Combinational victim selection and PLRU status update, shared by the fill and hit paths.
module icache_plru
    import icache_pkg::*;
(
    input  logic [SA_WORD_WIDTH-1:0] status_i,
    input  logic                     force_en_i,
    input  logic [WAY_BITS-1:0]      force_way_i,
    output logic [WAY_BITS-1:0]      victim_o,
    output logic [SA_WORD_WIDTH-1:0] status_o
);

    logic                found_inv;
    logic                found_old;
    logic                all_hot;
    logic [WAY_BITS-1:0] inv_way;
    logic [WAY_BITS-1:0] old_way;
    logic [WAY_BITS-1:0] upd_way;

    always_comb begin
        found_inv = 1'b0;
        found_old = 1'b0;
        inv_way   = '0;
        old_way   = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!found_inv && !status_i[w*STATUS_WIDTH + VALID_BIT]) begin
                found_inv = 1'b1;
                inv_way   = WAY_BITS'(w);
            end
            if (!found_old && !status_i[w*STATUS_WIDTH + RECENT_BIT]) begin
                found_old = 1'b1;
                old_way   = WAY_BITS'(w);
            end
        end
        victim_o = found_inv ? inv_way : (found_old ? old_way : '0);
        upd_way  = force_en_i ? force_way_i : victim_o;

        status_o = status_i;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (WAY_BITS'(w) == upd_way) begin
                status_o[w*STATUS_WIDTH + VALID_BIT]  = 1'b1;
                status_o[w*STATUS_WIDTH + RECENT_BIT] = 1'b1;
            end
        end

        // Once every way is valid and recent, age all but the one just touched.
        all_hot = 1'b1;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            all_hot = all_hot & status_o[w*STATUS_WIDTH + VALID_BIT]
                              & status_o[w*STATUS_WIDTH + RECENT_BIT];
        end
        if (all_hot) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                if (WAY_BITS'(w) != upd_way) begin
                    status_o[w*STATUS_WIDTH + RECENT_BIT] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/icache_array_updater.sv
// Write-side controller for the icache tag/status arrays: miss fills, hit PLRU updates, flush sweep.
// Flush sweep is built only when ICACHE_UPDATER_FLUSH_EN is defined.
module icache_array_updater
    import icache_pkg::*;
#(
    parameter int NUM_SETS       = 16,
    parameter int FLUSH_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      i_halt,
    input  logic [SET_BITS_WIDTH-1:0] i_fill_set,
    input  logic [TAG_WIDTH-1:0]      i_fill_tag,
    input  logic [SA_WORD_WIDTH-1:0]  i_fill_status,
    input  logic                      i_fill_valid,
    output logic                      o_fill_ready,
    output logic [WAY_BITS-1:0]       o_fill_way,
    input  logic [SET_BITS_WIDTH-1:0] i_hit_set,
    input  logic [WAY_BITS-1:0]       i_hit_way,
    input  logic [SA_WORD_WIDTH-1:0]  i_hit_status,
    input  logic                      i_hit_valid,
    output logic                      o_hit_ready,
    input  logic                      i_flush,
    output logic                      o_flush_busy,
    output logic [SET_BITS_WIDTH-1:0] o_w_ta_set_addr,
    output logic [TA_WORD_WIDTH-1:0]  o_w_ta_data,
    output logic [NUM_WAYS-1:0]       o_w_ta_mask,
    output logic                      o_w_ta_valid,
    input  logic                      i_ta_ready,
    output logic [SET_BITS_WIDTH-1:0] o_w_sa_set_addr,
    output logic [SA_WORD_WIDTH-1:0]  o_w_sa_data,
    output logic [NUM_WAYS-1:0]       o_w_sa_mask,
    output logic                      o_w_sa_valid,
    input  logic                      i_sa_ready,
    output logic                      o_done
);

    state_e                    state_q, state_d;
    logic                      ta_valid_q, ta_valid_d;
    logic [SET_BITS_WIDTH-1:0] ta_set_q, ta_set_d;
    logic [TA_WORD_WIDTH-1:0]  ta_data_q, ta_data_d;
    logic [NUM_WAYS-1:0]       ta_mask_q, ta_mask_d;
    logic                      sa_valid_q, sa_valid_d;
    logic [SET_BITS_WIDTH-1:0] sa_set_q, sa_set_d;
    logic [SA_WORD_WIDTH-1:0]  sa_data_q, sa_data_d;
    logic [NUM_WAYS-1:0]       sa_mask_q, sa_mask_d;
    logic [WAY_BITS-1:0]       fill_way_q, fill_way_d;
    logic                      done_q, done_d;

    logic                      flush_req;
    logic                      flush_busy;
    logic                      idle_ready;
    logic                      fill_acc;
    logic                      hit_acc;
    logic [SA_WORD_WIDTH-1:0]  plru_status_in;
    logic [WAY_BITS-1:0]       plru_victim;
    logic [SA_WORD_WIDTH-1:0]  plru_status_out;

`ifdef ICACHE_UPDATER_FLUSH_EN
    logic [SET_BITS_WIDTH-1:0] cnt_q, cnt_d;
    logic                      boot_done_q, boot_done_d;

    // The post-reset sweep is requested until the first sweep is launched.
    assign flush_req  = i_flush | ((FLUSH_ON_RESET != 0) & ~boot_done_q);
    assign flush_busy = (state_q == FLUSH);
`else
    logic unused_cfg;

    assign flush_req  = 1'b0;
    assign flush_busy = 1'b0;
    assign unused_cfg = ^{i_flush, (NUM_SETS != 0), (FLUSH_ON_RESET != 0)};
`endif

    assign idle_ready = ~arst & (state_q == IDLE) & ~i_halt & ~flush_req & ~flush_busy;
    assign fill_acc   = idle_ready & i_fill_valid;
    assign hit_acc    = idle_ready & i_hit_valid & ~i_fill_valid;

    // Fill wins the shared PLRU whenever it is requesting.
    assign plru_status_in = i_fill_valid ? i_fill_status : i_hit_status;

    icache_plru u_plru (
        .status_i    (plru_status_in),
        .force_en_i  (~i_fill_valid),
        .force_way_i (i_hit_way),
        .victim_o    (plru_victim),
        .status_o    (plru_status_out)
    );

    always_comb begin
        state_d    = state_q;
        ta_valid_d = ta_valid_q;
        ta_set_d   = ta_set_q;
        ta_data_d  = ta_data_q;
        ta_mask_d  = ta_mask_q;
        sa_valid_d = sa_valid_q;
        sa_set_d   = sa_set_q;
        sa_data_d  = sa_data_q;
        sa_mask_d  = sa_mask_q;
        fill_way_d = fill_way_q;
        done_d     = done_q;
`ifdef ICACHE_UPDATER_FLUSH_EN
        cnt_d       = cnt_q;
        boot_done_d = boot_done_q;
`endif
        if (!i_halt) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
`ifdef ICACHE_UPDATER_FLUSH_EN
                    if (flush_req) begin
                        state_d     = FLUSH;
                        boot_done_d = 1'b1;
                        cnt_d       = '0;
                        sa_valid_d  = 1'b1;
                        sa_set_d    = '0;
                        sa_data_d   = '0;
                        sa_mask_d   = '1;
                    end else
`endif
                    if (fill_acc) begin
                        state_d    = WRITE;
                        fill_way_d = plru_victim;
                        ta_valid_d = 1'b1;
                        ta_set_d   = i_fill_set;
                        ta_data_d  = {NUM_WAYS{i_fill_tag}};
                        ta_mask_d  = NUM_WAYS'(1) << plru_victim;
                        sa_valid_d = 1'b1;
                        sa_set_d   = i_fill_set;
                        sa_data_d  = plru_status_out;
                        sa_mask_d  = '1;
                    end else if (hit_acc) begin
                        state_d    = WRITE;
                        sa_valid_d = 1'b1;
                        sa_set_d   = i_hit_set;
                        sa_data_d  = plru_status_out;
                        sa_mask_d  = '1;
                    end
                end
                WRITE: begin
                    ta_valid_d = ta_valid_q & ~i_ta_ready;
                    sa_valid_d = sa_valid_q & ~i_sa_ready;
                    if (!ta_valid_d && !sa_valid_d) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
`ifdef ICACHE_UPDATER_FLUSH_EN
                FLUSH: begin
                    if (i_sa_ready) begin
                        if (cnt_q == SET_BITS_WIDTH'(NUM_SETS - 1)) begin
                            cnt_d      = '0;
                            sa_set_d   = '0;
                            sa_valid_d = 1'b0;
                            state_d    = IDLE;
                            done_d     = 1'b1;
                        end else begin
                            cnt_d    = cnt_q + SET_BITS_WIDTH'(1);
                            sa_set_d = cnt_q + SET_BITS_WIDTH'(1);
                        end
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            ta_valid_q  <= 1'b0;
            ta_set_q    <= '0;
            ta_data_q   <= '0;
            ta_mask_q   <= '0;
            sa_valid_q  <= 1'b0;
            sa_set_q    <= '0;
            sa_data_q   <= '0;
            sa_mask_q   <= '0;
            fill_way_q  <= '0;
            done_q      <= 1'b0;
`ifdef ICACHE_UPDATER_FLUSH_EN
            cnt_q       <= '0;
            boot_done_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ta_valid_q  <= ta_valid_d;
            ta_set_q    <= ta_set_d;
            ta_data_q   <= ta_data_d;
            ta_mask_q   <= ta_mask_d;
            sa_valid_q  <= sa_valid_d;
            sa_set_q    <= sa_set_d;
            sa_data_q   <= sa_data_d;
            sa_mask_q   <= sa_mask_d;
            fill_way_q  <= fill_way_d;
            done_q      <= done_d;
`ifdef ICACHE_UPDATER_FLUSH_EN
            cnt_q       <= cnt_d;
            boot_done_q <= boot_done_d;
`endif
        end
    end

    assign o_fill_ready    = idle_ready;
    assign o_hit_ready     = idle_ready;
    assign o_fill_way      = fill_way_q;
    assign o_flush_busy    = flush_busy;
    assign o_w_ta_set_addr = ta_set_q;
    assign o_w_ta_data     = ta_data_q;
    assign o_w_ta_mask     = ta_mask_q;
    assign o_w_ta_valid    = ta_valid_q;
    assign o_w_sa_set_addr = sa_set_q;
    assign o_w_sa_data     = sa_data_q;
    assign o_w_sa_mask     = sa_mask_q;
    assign o_w_sa_valid    = sa_valid_q;
    assign o_done          = done_q;

endmodule

// File: tb/tb_icache_array_updater.sv
// Directed self-checking bench for icache_array_updater; flush checks follow ICACHE_UPDATER_FLUSH_EN.
module tb_icache_array_updater;

    logic        clk = 1'b0;
    logic        arst;
    logic        i_halt;
    logic [3:0]  i_fill_set;
    logic [7:0]  i_fill_tag;
    logic [7:0]  i_fill_status;
    logic        i_fill_valid;
    logic        o_fill_ready;
    logic [1:0]  o_fill_way;
    logic [3:0]  i_hit_set;
    logic [1:0]  i_hit_way;
    logic [7:0]  i_hit_status;
    logic        i_hit_valid;
    logic        o_hit_ready;
    logic        i_flush;
    logic        o_flush_busy;
    logic [3:0]  o_w_ta_set_addr;
    logic [31:0] o_w_ta_data;
    logic [3:0]  o_w_ta_mask;
    logic        o_w_ta_valid;
    logic        i_ta_ready;
    logic [3:0]  o_w_sa_set_addr;
    logic [7:0]  o_w_sa_data;
    logic [3:0]  o_w_sa_mask;
    logic        o_w_sa_valid;
    logic        i_sa_ready;
    logic        o_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    icache_array_updater #(.NUM_SETS(16), .FLUSH_ON_RESET(1)) dut (
        .clk             (clk),
        .arst            (arst),
        .i_halt          (i_halt),
        .i_fill_set      (i_fill_set),
        .i_fill_tag      (i_fill_tag),
        .i_fill_status   (i_fill_status),
        .i_fill_valid    (i_fill_valid),
        .o_fill_ready    (o_fill_ready),
        .o_fill_way      (o_fill_way),
        .i_hit_set       (i_hit_set),
        .i_hit_way       (i_hit_way),
        .i_hit_status    (i_hit_status),
        .i_hit_valid     (i_hit_valid),
        .o_hit_ready     (o_hit_ready),
        .i_flush         (i_flush),
        .o_flush_busy    (o_flush_busy),
        .o_w_ta_set_addr (o_w_ta_set_addr),
        .o_w_ta_data     (o_w_ta_data),
        .o_w_ta_mask     (o_w_ta_mask),
        .o_w_ta_valid    (o_w_ta_valid),
        .i_ta_ready      (i_ta_ready),
        .o_w_sa_set_addr (o_w_sa_set_addr),
        .o_w_sa_data     (o_w_sa_data),
        .o_w_sa_mask     (o_w_sa_mask),
        .o_w_sa_valid    (o_w_sa_valid),
        .i_sa_ready      (i_sa_ready),
        .o_done          (o_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ta_valid"}, o_w_ta_valid, 0);
        chk({tag, "_sa_valid"}, o_w_sa_valid, 0);
        chk({tag, "_ta_data"},  o_w_ta_data, 0);
        chk({tag, "_sa_set"},   o_w_sa_set_addr, 0);
        chk({tag, "_sa_data"},  o_w_sa_data, 0);
        chk({tag, "_done"},     o_done, 0);
        chk({tag, "_busy"},     o_flush_busy, 0);
        chk({tag, "_fill_rdy"}, o_fill_ready, 0);
        chk({tag, "_hit_rdy"},  o_hit_ready, 0);
        chk({tag, "_fill_way"}, o_fill_way, 0);
    endtask

    // Called at a negedge in IDLE; both array readies assumed high.
    task automatic do_fill(input logic [3:0] set, input logic [7:0] tag, input logic [7:0] st,
                           input logic [1:0] exp_way, input logic [3:0] exp_mask,
                           input logic [31:0] exp_tdata, input logic [7:0] exp_sa);
        i_fill_set    = set;
        i_fill_tag    = tag;
        i_fill_status = st;
        i_fill_valid  = 1'b1;
        #1 chk("fill_rdy", o_fill_ready, 1);
        @(negedge clk);
        i_fill_valid = 1'b0;
        chk("fill_ta_valid", o_w_ta_valid, 1);
        chk("fill_ta_set",   o_w_ta_set_addr, set);
        chk("fill_ta_data",  o_w_ta_data, exp_tdata);
        chk("fill_ta_mask",  o_w_ta_mask, exp_mask);
        chk("fill_sa_valid", o_w_sa_valid, 1);
        chk("fill_sa_set",   o_w_sa_set_addr, set);
        chk("fill_sa_data",  o_w_sa_data, exp_sa);
        chk("fill_sa_mask",  o_w_sa_mask, 4'hF);
        chk("fill_way",      o_fill_way, exp_way);
        chk("fill_busy_rdy", o_fill_ready, 0);
        chk("fill_done_n1",  o_done, 0);
        @(negedge clk);
        chk("fill_done_n2",  o_done, 1);
        chk("fill_ta_drop",  o_w_ta_valid, 0);
        chk("fill_sa_drop",  o_w_sa_valid, 0);
        chk("fill_rdy_n2",   o_fill_ready, 1);
        @(negedge clk);
        chk("fill_done_off", o_done, 0);
    endtask

    task automatic do_hit(input logic [3:0] set, input logic [1:0] way, input logic [7:0] st,
                          input logic [7:0] exp_sa, input logic [1:0] exp_fill_way);
        i_hit_set    = set;
        i_hit_way    = way;
        i_hit_status = st;
        i_hit_valid  = 1'b1;
        #1 chk("hit_rdy", o_hit_ready, 1);
        @(negedge clk);
        i_hit_valid = 1'b0;
        chk("hit_ta_valid", o_w_ta_valid, 0);
        chk("hit_sa_valid", o_w_sa_valid, 1);
        chk("hit_sa_set",   o_w_sa_set_addr, set);
        chk("hit_sa_data",  o_w_sa_data, exp_sa);
        chk("hit_sa_mask",  o_w_sa_mask, 4'hF);
        chk("hit_fill_way", o_fill_way, exp_fill_way);
        @(negedge clk);
        chk("hit_done",     o_done, 1);
        chk("hit_ta_quiet", o_w_ta_valid, 0);
        @(negedge clk);
    endtask

`ifdef ICACHE_UPDATER_FLUSH_EN
    // Entered at the first negedge of a sweep; optionally raises a fill at step fill_at.
    task automatic run_sweep(input int fill_at);
        for (int i = 0; i < 16; i++) begin
            chk("sweep_busy",     o_flush_busy, 1);
            chk("sweep_sa_valid", o_w_sa_valid, 1);
            chk("sweep_sa_set",   o_w_sa_set_addr, i);
            chk("sweep_sa_data",  o_w_sa_data, 0);
            chk("sweep_sa_mask",  o_w_sa_mask, 4'hF);
            chk("sweep_ta_quiet", o_w_ta_valid, 0);
            chk("sweep_fill_rdy", o_fill_ready, 0);
            chk("sweep_no_done",  o_done, 0);
            if (i == fill_at) begin
                i_fill_set    = 4'd9;
                i_fill_tag    = 8'h99;
                i_fill_status = 8'h00;
                i_fill_valid  = 1'b1;
            end
            @(negedge clk);
        end
        chk("sweep_end_busy", o_flush_busy, 0);
        chk("sweep_end_done", o_done, 1);
        chk("sweep_end_sav",  o_w_sa_valid, 0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        arst          = 1'b1;
        i_halt        = 1'b0;
        i_fill_set    = '0;
        i_fill_tag    = '0;
        i_fill_status = '0;
        i_fill_valid  = 1'b0;
        i_hit_set     = '0;
        i_hit_way     = '0;
        i_hit_status  = '0;
        i_hit_valid   = 1'b0;
        i_flush       = 1'b0;
        i_ta_ready    = 1'b1;
        i_sa_ready    = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("rst");
        arst = 1'b0;
`ifdef ICACHE_UPDATER_FLUSH_EN
        @(negedge clk);
        run_sweep(-1);
`else
        #1 chk("post_rst_rdy", o_fill_ready, 1);
        @(negedge clk);
`endif

        do_fill(4'd3, 8'h5A, 8'h00, 2'd0, 4'b0001, 32'h5A5A5A5A, 8'h03);
        do_fill(4'd7, 8'hC4, 8'hCF, 2'd2, 4'b0100, 32'hC4C4C4C4, 8'hBA);
        do_fill(4'd7, 8'h21, 8'hFE, 2'd0, 4'b0001, 32'h21212121, 8'hAB);
        do_hit(4'd5, 2'd1, 8'hAB, 8'hAF, 2'd0);

        // Simultaneous fill and hit: fill first, hit afterwards.
        i_fill_set = 4'd1; i_fill_tag = 8'h11; i_fill_status = 8'h00; i_fill_valid = 1'b1;
        i_hit_set  = 4'd2; i_hit_way  = 2'd3;  i_hit_status  = 8'h03; i_hit_valid  = 1'b1;
        #1 chk("prio_rdy", o_hit_ready, 1);
        @(negedge clk);
        i_fill_valid = 1'b0;
        chk("prio_ta_valid", o_w_ta_valid, 1);
        chk("prio_ta_set",   o_w_ta_set_addr, 1);
        chk("prio_sa_data",  o_w_sa_data, 8'h03);
        chk("prio_hit_rdy",  o_hit_ready, 0);
        @(negedge clk);
        chk("prio_done1",    o_done, 1);
        chk("prio_hit_rdy2", o_hit_ready, 1);
        @(negedge clk);
        i_hit_valid = 1'b0;
        chk("prio_hit_ta",   o_w_ta_valid, 0);
        chk("prio_hit_sav",  o_w_sa_valid, 1);
        chk("prio_hit_set",  o_w_sa_set_addr, 2);
        chk("prio_hit_data", o_w_sa_data, 8'hC3);
        @(negedge clk);
        chk("prio_done2",    o_done, 1);
        @(negedge clk);

        // SA back-pressure for three cycles.
        i_sa_ready = 1'b0;
        i_fill_set = 4'd4; i_fill_tag = 8'h3C; i_fill_status = 8'h0F; i_fill_valid = 1'b1;
        #1 chk("bp_rdy", o_fill_ready, 1);
        @(negedge clk);
        i_fill_valid = 1'b0;
        chk("bp_ta_v1", o_w_ta_valid, 1);
        chk("bp_ta_mask", o_w_ta_mask, 4'b0100);
        chk("bp_sa_v1", o_w_sa_valid, 1);
        chk("bp_way", o_fill_way, 2);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("bp_ta_gone",  o_w_ta_valid, 0);
            chk("bp_sa_hold",  o_w_sa_valid, 1);
            chk("bp_sa_set",   o_w_sa_set_addr, 4);
            chk("bp_sa_data",  o_w_sa_data, 8'h3F);
            chk("bp_rdy_low",  o_fill_ready, 0);
            chk("bp_no_done",  o_done, 0);
        end
        i_sa_ready = 1'b1;
        @(negedge clk);
        chk("bp_done", o_done, 1);
        chk("bp_sa_drop", o_w_sa_valid, 0);
        chk("bp_rdy_back", o_fill_ready, 1);
        @(negedge clk);

        // Halt in IDLE blocks acceptance, then halt during WRITE freezes the writes.
        i_halt = 1'b1;
        i_fill_set = 4'd6; i_fill_tag = 8'h77; i_fill_status = 8'h00; i_fill_valid = 1'b1;
        #1 chk("halt_idle_rdy", o_fill_ready, 0);
        @(negedge clk);
        chk("halt_idle_noacc", o_w_ta_valid, 0);
        i_halt = 1'b0;
        #1 chk("halt_rdy_back", o_fill_ready, 1);
        @(negedge clk);
        i_fill_valid = 1'b0;
        chk("halt_ta_v", o_w_ta_valid, 1);
        i_halt = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("halt_ta_hold", o_w_ta_valid, 1);
            chk("halt_sa_hold", o_w_sa_valid, 1);
            chk("halt_sa_set",  o_w_sa_set_addr, 6);
            chk("halt_no_done", o_done, 0);
            chk("halt_rdy_low", o_fill_ready, 0);
        end
        i_halt = 1'b0;
        @(negedge clk);
        chk("halt_done", o_done, 1);
        chk("halt_ta_drop", o_w_ta_valid, 0);
        @(negedge clk);

`ifdef ICACHE_UPDATER_FLUSH_EN
        i_flush = 1'b1;
        #1 chk("flush_blocks_rdy", o_fill_ready, 0);
        @(negedge clk);
        i_flush = 1'b0;
        run_sweep(5);
        do_fill(4'd9, 8'h99, 8'h00, 2'd0, 4'b0001, 32'h99999999, 8'h03);

        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_sweep_set", o_w_sa_set_addr, 9);
        arst = 1'b1;
        #1 chk_all_zero("rst_flush");
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        run_sweep(-1);
`else
        i_flush = 1'b1;
        #1 chk("flush_ign_rdy", o_fill_ready, 1);
        chk("flush_ign_busy", o_flush_busy, 0);
        do_fill(4'd9, 8'h99, 8'h00, 2'd0, 4'b0001, 32'h99999999, 8'h03);
        chk("flush_ign_busy2", o_flush_busy, 0);
        i_flush = 1'b0;
`endif

        // Reset while an SA write is still pending.
        i_sa_ready = 1'b0;
        i_fill_set = 4'd2; i_fill_tag = 8'h42; i_fill_status = 8'h00; i_fill_valid = 1'b1;
        @(negedge clk);
        i_fill_valid = 1'b0;
        @(negedge clk);
        chk("rstop_pending", o_w_sa_valid, 1);
        arst = 1'b1;
        #1 chk_all_zero("rst_op");
        i_sa_ready = 1'b1;
        @(negedge clk);
        arst = 1'b0;
`ifdef ICACHE_UPDATER_FLUSH_EN
        @(negedge clk);
        run_sweep(-1);
`else
        #1 chk("rstop_rdy", o_fill_ready, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_array_updater.md
Name: icache_array_updater

Overview:
- Write-side controller for the icache tag array (TA) and status array (SA).
- Turns three kinds of request into masked writes on the TA/SA write ports of the stage-1 array block:
  - miss fills: victim selection, new tag, PLRU update;
  - hit LRU updates;
  - whole-cache flush.
- Sits beside stage 1; the miss/hit resolution logic drives it with the set, tag and the status word stage 1 read.

Parameters:
- NUM_SETS, 16, number of sets; must equal 2**SET_BITS_WIDTH.
- FLUSH_ON_RESET, 1, when 1 a flush sweep starts automatically in the first cycle after reset deasserts.

Ports:
- clk  in  1  clock
- arst  in  1  asynchronous reset, active-high
- i_halt  in  1  freeze: no state, counter or output change while high
- i_fill_set  in  4  set of the missing line
- i_fill_tag  in  8  tag of the missing line
- i_fill_status  in  8  current status word of that set
- i_fill_valid  in  1  fill request
- o_fill_ready  out  1  fill request accepted when valid&ready
- o_fill_way  out  2  victim way of the last accepted fill; held until the next fill
- i_hit_set  in  4  set that hit
- i_hit_way  in  2  way index that hit
- i_hit_status  in  8  current status word of that set
- i_hit_valid  in  1  hit-update request
- o_hit_ready  out  1  hit request accepted when valid&ready
- i_flush  in  1  flush request, sampled as a level
- o_flush_busy  out  1  high while the sweep runs
- o_w_ta_set_addr  out  4  TA write set
- o_w_ta_data  out  32  TA write data, 8 bits per way, way w at [8w+7:8w]
- o_w_ta_mask  out  4  TA write way mask
- o_w_ta_valid  out  1  TA write valid
- i_ta_ready  in  1  TA accepts the write on a clock edge where valid&ready&~i_halt
- o_w_sa_set_addr, o_w_sa_data(8), o_w_sa_mask(4), o_w_sa_valid  out  SA write channel, same rules as TA
- i_sa_ready  in  1  SA ready
- o_done  out  1  one-cycle pulse when an operation fully retires

Behaviour:
- Reset (arst high, asynchronous):
  - all outputs 0, state IDLE, flush counter 0, pending flags 0;
  - an operation in flight is dropped; no partial-write recovery.
- Status field for way w is bits [2w+1:2w] = {valid, recent}.
- Victim selection:
  - the lowest-index way with valid=0;
  - otherwise the lowest-index way with recent=0;
  - otherwise way 0.
- PLRU update of way v:
  - set way v to {1,1};
  - if all four ways are then valid and recent, clear recent on every way except v.
- o_fill_ready = o_hit_ready = (state==IDLE) & ~i_halt & ~i_flush & ~o_flush_busy.
- Priority in IDLE: flush > fill > hit. If fill and hit are valid together, only fill is accepted; hit stays pending with its ready low.
- Fill accepted on edge N:
  - From cycle N+1, both writes are valid in the same cycle:
    - TA: set=i_fill_set, data = tag replicated into all 4 lanes, mask = one-hot victim;
    - SA: set=i_fill_set, data = PLRU(i_fill_status, victim), mask=4'b1111.
  - State WRITE.
- Hit accepted:
  - SA write only, data = PLRU(i_hit_status, i_hit_way), mask=4'b1111;
  - o_w_ta_valid stays 0.
- WRITE state:
  - Each channel holds its valid/addr/data/mask stable until it is accepted, then drops that valid independently.
  - When no channel is pending: o_done pulses for 1 cycle and state returns to IDLE.
  - Minimum latency, both ready: accept → o_*_valid at N+1 → o_done at N+2 → ready again at N+2.
- FLUSH state (entered from IDLE on i_flush):
  - SA write, set = counter, data=0, mask=4'b1111.
  - On each acceptance the counter increments.
  - After set NUM_SETS-1 is accepted: counter wraps to 0, o_done pulses, state IDLE.
  - i_flush remaining high re-triggers another sweep.
  - Tags are not written.
- i_halt high: registers hold, ready outputs low, no acceptance counts even if array ready is high.

Optional Feature:
- ICACHE_UPDATER_FLUSH_EN:
  - Defined: FLUSH state, counter and FLUSH_ON_RESET behave as above.
  - Undefined: i_flush is ignored, o_flush_busy is tied 0, FLUSH_ON_RESET has no effect, no counter is synthesized.

Decomposition:
- Package icache_pkg holds:
  - SET_BITS_WIDTH=4, TAG_WIDTH=8, NUM_WAYS=4, STATUS_WIDTH=2, TA_WORD_WIDTH=32, SA_WORD_WIDTH=8;
  - status bit indices VALID_BIT=1, RECENT_BIT=0;
  - state encoding IDLE/WRITE/FLUSH.
- Sub-module icache_plru: combinational; takes a status word and an optional forced way, returns the victim index and the updated status word. It is shared by the fill and hit paths.

Test Plan:
- Fill set 3, tag 0x5A, status 0x00, both ready →
  - o_fill_way=0, TA mask 4'b0001, TA data 0x5A5A5A5A;
  - SA data 0x03;
  - o_done on the 2nd cycle after acceptance.
- Fill set 7, status 0xCF (way2 invalid) → o_fill_way=2, TA mask 4'b0100, SA data 0xBA. Fill with status 0xFE → o_fill_way=0, SA data 0xAB.
- Hit set 5, way 1, status 0xAB → SA-only write, data 0xAF (no clear), mask 4'b1111, o_w_ta_valid stays 0.
- Fill with i_sa_ready low for 3 cycles →
  - TA write retires in 1 cycle;
  - SA valid, addr and data stay stable 3 cycles;
  - o_fill_ready low until o_done.
  - Repeat with i_halt high for 2 cycles: no acceptance while halted.
- Flush pulse with both ready → 16 SA writes, sets 0..15, data 0x00, o_flush_busy high 16 cycles, single o_done. A fill raised mid-flush is not accepted until the sweep ends.
- arst asserted at flush set 9 → all outputs 0 immediately. With FLUSH_ON_RESET=1 a new sweep starts from set 0 after deassertion.
